// File: rtl/svreal_check_pkg.sv
// Shared types and elaboration-time helpers for the fixed-point result checker:
// FSM state encoding plus the common exponent and internal width calculations.
package svreal_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    DIFF   = 3'd2,
    CMP    = 3'd3,
    REPORT = 3'd4
  } state_t;

  function automatic int common_exp(input int dut_exp, input int ref_exp, input int tol_exp);
    int e;
    e = dut_exp;
    if (ref_exp < e) e = ref_exp;
    if (tol_exp < e) e = tol_exp;
    return e;
  endfunction

  // Widest operand after shifting to the common exponent, plus two guard bits
  // so the difference and its magnitude can never wrap.
  function automatic int int_width(input int dut_width, input int dut_exp,
                                   input int ref_width, input int ref_exp,
                                   input int tol_width, input int tol_exp);
    int e;
    int w;
    e = common_exp(dut_exp, ref_exp, tol_exp);
    w = dut_width + dut_exp - e;
    if (ref_width + ref_exp - e > w) w = ref_width + ref_exp - e;
    if (tol_width + tol_exp - e > w) w = tol_width + tol_exp - e;
    return w + 2;
  endfunction

endpackage

// File: rtl/svreal_align.sv
// Re-expresses one signed fixed-point operand at a smaller exponent by
// sign-extending to the internal width and shifting left.
module svreal_align #(
  parameter int IN_WIDTH  = 18,
  parameter int IN_EXP    = -10,
  parameter int OUT_EXP   = -10,
  parameter int OUT_WIDTH = 20
) (
  input  logic signed [IN_WIDTH-1:0]  in_val,
  output logic signed [OUT_WIDTH-1:0] out_val
);

  localparam int SHIFT = IN_EXP - OUT_EXP;

  logic signed [OUT_WIDTH-1:0] ext;

  assign ext     = {{(OUT_WIDTH-IN_WIDTH){in_val[IN_WIDTH-1]}}, in_val};
  assign out_val = ext <<< SHIFT;

endmodule

// File: rtl/svreal_result_checker.sv
// Compares a fixed-point DUT value against a reference within a tolerance,
// reporting a pass/fail verdict per sample and keeping saturating tallies.
module svreal_result_checker
  import svreal_check_pkg::*;
#(
  parameter int DUT_WIDTH = 18,
  parameter int DUT_EXP   = -10,
  parameter int REF_WIDTH = 18,
  parameter int REF_EXP   = -8,
  parameter int TOL_WIDTH = 18,
  parameter int TOL_EXP   = -10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk_ext,
  input  logic                        rst_ext,
  input  logic                        clear_ext,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DUT_WIDTH-1:0] dut_val,
  input  logic signed [REF_WIDTH-1:0] ref_val,
  input  logic signed [TOL_WIDTH-1:0] tol_val,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_pass,
  output logic [CNT_WIDTH-1:0]        pass_cnt,
  output logic [CNT_WIDTH-1:0]        fail_cnt,
  output logic                        any_fail
);

  localparam int E = common_exp(DUT_EXP, REF_EXP, TOL_EXP);
  localparam int W = int_width(DUT_WIDTH, DUT_EXP, REF_WIDTH, REF_EXP, TOL_WIDTH, TOL_EXP);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t state;
  state_t state_next;

  logic signed [DUT_WIDTH-1:0] dut_raw;
  logic signed [REF_WIDTH-1:0] ref_raw;
  logic signed [TOL_WIDTH-1:0] tol_raw;
  logic signed [W-1:0]         dut_shift;
  logic signed [W-1:0]         ref_shift;
  logic signed [W-1:0]         tol_shift;
  logic signed [W-1:0]         dut_al;
  logic signed [W-1:0]         ref_al;
  logic signed [W-1:0]         tol_al;
  logic signed [W-1:0]         diff;
  logic [W-1:0]                absdiff;
  logic                        res_hs;

  svreal_align #(.IN_WIDTH(DUT_WIDTH), .IN_EXP(DUT_EXP), .OUT_EXP(E), .OUT_WIDTH(W))
    u_align_dut (.in_val(dut_raw), .out_val(dut_shift));
  svreal_align #(.IN_WIDTH(REF_WIDTH), .IN_EXP(REF_EXP), .OUT_EXP(E), .OUT_WIDTH(W))
    u_align_ref (.in_val(ref_raw), .out_val(ref_shift));
  svreal_align #(.IN_WIDTH(TOL_WIDTH), .IN_EXP(TOL_EXP), .OUT_EXP(E), .OUT_WIDTH(W))
    u_align_tol (.in_val(tol_raw), .out_val(tol_shift));

  // The guard bits keep this in range even for two most-negative operands.
  assign diff   = dut_al - ref_al;
  assign res_hs = res_valid && res_ready;

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ALIGN;
        else          state_next = IDLE;
      end
      ALIGN:  state_next = DIFF;
      DIFF:   state_next = CMP;
      CMP:    state_next = REPORT;
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
        else           state_next = REPORT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) begin
      dut_raw  <= '0;
      ref_raw  <= '0;
      tol_raw  <= '0;
      dut_al   <= '0;
      ref_al   <= '0;
      tol_al   <= '0;
      absdiff  <= '0;
      res_pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dut_raw <= dut_val;
            ref_raw <= ref_val;
            tol_raw <= tol_val;
          end
        end
        ALIGN: begin
          dut_al <= dut_shift;
          ref_al <= ref_shift;
          tol_al <= tol_shift;
        end
        DIFF: absdiff <= diff[W-1] ? unsigned'(-diff) : unsigned'(diff);
        // A negative tolerance has its sign bit set and can never pass.
        CMP:  res_pass <= !tol_al[W-1] && (absdiff <= unsigned'(tol_al));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ext or posedge rst_ext) begin
    if (rst_ext) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else if (clear_ext) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      any_fail <= 1'b0;
    end else if (res_hs) begin
      if (res_pass) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        any_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svreal_result_checker.sv
// Scoreboard bench: stimulus pushes hand-computed verdicts, a negedge monitor
// pops them on each result handshake and keeps a model of the tallies.
module tb_svreal_result_checker;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear_ext = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] dut_val = '0;
  logic signed [17:0] ref_val = '0;
  logic signed [17:0] tol_val = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic               res_pass;
  logic [15:0]        pass_cnt;
  logic [15:0]        fail_cnt;
  logic               any_fail;

  int checks = 0;
  int errors = 0;

  bit   exp_q[$];
  int   m_pass = 0;
  int   m_fail = 0;
  bit   m_any  = 1'b0;
  bit   waiting = 1'b0;
  int   lat = 0;

  svreal_result_checker dut (
    .clk_ext(clk), .rst_ext(rst), .clear_ext(clear_ext),
    .in_valid(in_valid), .in_ready(in_ready),
    .dut_val(dut_val), .ref_val(ref_val), .tol_val(tol_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: latency tracking, verdict scoreboard and tally model.
  always @(negedge clk) begin
    bit e;
    if (rst) begin
      exp_q.delete();
      m_pass  = 0;
      m_fail  = 0;
      m_any   = 1'b0;
      waiting = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        waiting = 1'b1;
        lat     = 0;
      end else if (waiting) begin
        lat++;
        if (res_valid) begin
          waiting = 1'b0;
          chk("latency", lat, 4);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got verdict %0d with empty scoreboard", res_pass);
        end else begin
          e = exp_q.pop_front();
          chk("res_pass", res_pass, e);
          if (!clear_ext) begin
            if (e) m_pass++;
            else begin
              m_fail++;
              m_any = 1'b1;
            end
          end
        end
      end
      if (clear_ext) begin
        m_pass = 0;
        m_fail = 0;
        m_any  = 1'b0;
      end
    end
  end

  task automatic send(input int d, input int r, input int t, input bit exp_pass);
    bit got = 1'b0;
    dut_val  = 18'(d);
    ref_val  = 18'(r);
    tol_val  = 18'(t);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (got) exp_q.push_back(exp_pass);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("drain_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pass_cnt"}, pass_cnt, m_pass);
    chk({tag, "_fail_cnt"}, fail_cnt, m_fail);
    chk({tag, "_any_fail"}, any_fail, m_any);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("valid_timeout", n, 0);
  endtask

  initial begin
    bit held;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pass", res_pass, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_any_fail", any_fail, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(1024, 256, 0, 1'b1);            drain(); check_counts("exact");
    chk("exact_pass_cnt_abs", pass_cnt, 1);
    send(1030, 256, 5, 1'b0);            drain(); check_counts("tol5");
    chk("tol5_fail_cnt_abs", fail_cnt, 1);
    send(1030, 256, 6, 1'b1);            drain(); check_counts("tol6");
    send(-131072, 0, 0, 1'b0);           drain(); check_counts("mostneg");
    send(-131072, 0, 131071, 1'b0);      drain(); check_counts("mostneg_tolmax");
    send(-131072, -32768, 0, 1'b1);      drain(); check_counts("neg_equal");
    send(1024, 256, -1, 1'b0);           drain(); check_counts("negtol");

    // Backpressure: verdict must hold while in_valid is ignored.
    res_ready = 1'b0;
    send(1024, 256, 0, 1'b1);
    wait_valid();
    held     = res_pass;
    dut_val  = 18'sd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_res_pass", res_pass, held);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    drain();
    check_counts("hold");

    // Clear coinciding with a result handshake.
    res_ready = 1'b0;
    send(1030, 256, 0, 1'b0);
    wait_valid();
    res_ready = 1'b1;
    clear_ext = 1'b1;
    @(posedge clk); #1;
    clear_ext = 1'b0;
    chk("clear_pass_cnt", pass_cnt, 0);
    chk("clear_fail_cnt", fail_cnt, 0);
    chk("clear_any_fail", any_fail, 0);
    drain();

    send(1030, 256, 0, 1'b0);            drain(); check_counts("pre_reset");

    // Reset pulse while the sample sits in DIFF.
    send(1024, 256, 0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_pass_cnt", pass_cnt, 0);
    chk("midrst_fail_cnt", fail_cnt, 0);
    chk("midrst_any_fail", any_fail, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(1024, 256, 0, 1'b1);            drain(); check_counts("post_reset");
    chk("post_reset_pass_abs", pass_cnt, 1);
    chk("post_reset_fail_abs", fail_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
